// File: rtl/load_pkg.sv
// Shared definitions for the load path: funct3 codes, FSM state encoding
// and access-size decode.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Access size in bytes; 0 for codes that are never a load.
    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU:  return 4'd1;
            F3_LH, F3_LHU:  return 4'd2;
            F3_LW, F3_LWU:  return 4'd4;
            F3_LD:          return 4'd8;
            default:        return 4'd0;
        endcase
    endfunction

    // LWU and LD only exist on a 64-bit datapath.
    function automatic logic f3_legal(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW: return 1'b1;
            F3_LWU, F3_LD:                       return (xlen == 64);
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load formatter: stitches two memory beats, shifts the
// addressed bytes down to bit 0 and sign- or zero-extends them.
module load_align_ext
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             beat0,
    input  logic [XLEN-1:0]             beat1,
    input  logic [$clog2(XLEN/8)-1:0]   off,
    input  logic [2:0]                  funct3,
    output logic [XLEN-1:0]             result
);

    logic [2*XLEN-1:0]  both;
    logic [XLEN-1:0]    win;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    assign both   = {beat1, beat0};
    assign win    = both[{off, 3'b000} +: XLEN];
    assign byte_s = win[7:0];
    assign half_s = win[15:0];
    assign word_s = win[31:0];

    // Extension by access type; the signed casts replicate the top data bit.
    always_comb begin
        result = win;
        case (funct3)
            F3_LB:   result = XLEN'(byte_s);
            F3_LBU:  result = XLEN'(win[7:0]);
            F3_LH:   result = XLEN'(half_s);
            F3_LHU:  result = XLEN'(win[15:0]);
            F3_LW:   result = XLEN'(word_s);
            F3_LWU:  result = XLEN'(win[31:0]);
            default: result = win;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Sequential load unit: issues one or two aligned read beats per request,
// formats the result and returns it over a valid/ready handshake.
module load_unit
    import load_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_err
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_t            state, state_nxt;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   addr_q;
    logic              split_q;
    logic [XLEN-1:0]   beat0_q;

    logic [OFF_W-1:0]  off_in;
    logic [4:0]        end_in;
    logic              split_in, bad_in, accept, fill;
    logic [XLEN-1:0]   base_addr, ext_b0, ext_b1, ext_data;

    assign off_in   = req_addr[OFF_W-1:0];
    assign end_in   = 5'(off_in) + 5'(f3_size(req_funct3));
    assign split_in = end_in > 5'(BYTES);
    assign bad_in   = !f3_legal(req_funct3, XLEN) || (split_in && !MISALIGNED_EN);
    assign accept   = (state == S_IDLE) && req_valid;

    assign req_ready     = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQ0) || (state == S_REQ1);
    assign resp_valid    = (state == S_RESP);
    assign base_addr     = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    // Beat address; the second beat wraps naturally past the top of memory.
    always_comb begin
        mem_addr = '0;
        if (state == S_REQ0) mem_addr = base_addr;
        if (state == S_REQ1) mem_addr = base_addr + XLEN'(BYTES);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: error requests skip memory entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid)     state_nxt = bad_in ? S_RESP : S_REQ0;
            S_REQ0:  if (mem_req_ready) state_nxt = S_WAIT0;
            S_WAIT0: if (mem_rvalid)    state_nxt = split_q ? S_REQ1 : S_RESP;
            S_REQ1:  if (mem_req_ready) state_nxt = S_WAIT1;
            S_WAIT1: if (mem_rvalid)    state_nxt = S_RESP;
            S_RESP:  if (resp_ready)    state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    // Request and first-beat capture; data only, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            split_q <= split_in;
        end
        if ((state == S_WAIT0) && mem_rvalid) beat0_q <= mem_rdata;
    end

    // The final beat is taken straight from the bus so the result registers
    // in the same cycle the data arrives.
    assign ext_b0 = (state == S_WAIT0) ? mem_rdata : beat0_q;
    assign ext_b1 = (state == S_WAIT1) ? mem_rdata : '0;
    assign fill   = mem_rvalid && (((state == S_WAIT0) && !split_q) || (state == S_WAIT1));

    load_align_ext #(.XLEN(XLEN)) u_align (
        .beat0  (ext_b0),
        .beat1  (ext_b1),
        .off    (addr_q[OFF_W-1:0]),
        .funct3 (f3_q),
        .result (ext_data)
    );

    // Response registers, loaded on entry to RESP and held until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (accept && bad_in) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
        end else if (fill) begin
            resp_data <= ext_data;
            resp_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: three instances (32-bit split-capable, 32-bit strict,
// 64-bit) share one byte-addressed memory model.
module tb_load_unit;
    import load_pkg::*;

    logic        clk, rst;
    logic        rv, mem_req_ready, resp_ready, mem_hold, inj_rv;
    logic [2:0]  f3;
    logic [63:0] addr;
    int          sel;
    logic [2:0]  req_ready, mreqv, resp_valid, resp_err, mrv;
    logic [31:0] ma0, ma1, rd0_o, rd1_o, rdat0, rdat1;
    logic [63:0] ma2, rd2_o, rdat2;
    logic [7:0]  bmem [512];
    logic [63:0] req_log [$];
    int          nchk, nerr;
    logic        c_rr, c_mv, c_rv, c_err;
    logic [63:0] c_rd, c_ma;

    load_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv && sel == 0), .req_ready(req_ready[0]),
        .req_funct3(f3), .req_addr(addr[31:0]), .mem_req_valid(mreqv[0]),
        .mem_req_ready(mem_req_ready), .mem_addr(ma0), .mem_rvalid(mrv[0] | (inj_rv && sel == 0)),
        .mem_rdata(rdat0), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_data(rd0_o), .resp_err(resp_err[0]));

    load_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv && sel == 1), .req_ready(req_ready[1]),
        .req_funct3(f3), .req_addr(addr[31:0]), .mem_req_valid(mreqv[1]),
        .mem_req_ready(mem_req_ready), .mem_addr(ma1), .mem_rvalid(mrv[1] | (inj_rv && sel == 1)),
        .mem_rdata(rdat1), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_data(rd1_o), .resp_err(resp_err[1]));

    load_unit #(.XLEN(64), .MISALIGNED_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rv && sel == 2), .req_ready(req_ready[2]),
        .req_funct3(f3), .req_addr(addr), .mem_req_valid(mreqv[2]),
        .mem_req_ready(mem_req_ready), .mem_addr(ma2), .mem_rvalid(mrv[2] | (inj_rv && sel == 2)),
        .mem_rdata(rdat2), .resp_valid(resp_valid[2]), .resp_ready(resp_ready),
        .resp_data(rd2_o), .resp_err(resp_err[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // View of the currently selected instance.
    always_comb begin
        case (sel)
            1: begin
                c_rr = req_ready[1]; c_mv = mreqv[1]; c_rv = resp_valid[1]; c_err = resp_err[1];
                c_rd = 64'(rd1_o); c_ma = 64'(ma1);
            end
            2: begin
                c_rr = req_ready[2]; c_mv = mreqv[2]; c_rv = resp_valid[2]; c_err = resp_err[2];
                c_rd = rd2_o; c_ma = ma2;
            end
            default: begin
                c_rr = req_ready[0]; c_mv = mreqv[0]; c_rv = resp_valid[0]; c_err = resp_err[0];
                c_rd = 64'(rd0_o); c_ma = 64'(ma0);
            end
        endcase
    end

    function automatic logic [63:0] beat(input logic [63:0] a, input int nb);
        logic [63:0] r = '0;
        for (int i = 0; i < nb; i++)
            r[8*i +: 8] = bmem[int'((a + 64'(i)) & 64'd511)];
        return r;
    endfunction

    // Memory: accepts a request and answers the following cycle.
    always @(posedge clk) begin
        if (rst) begin
            mrv <= '0;
        end else begin
            mrv <= '0;
            if (mreqv[0] && mem_req_ready) begin
                req_log.push_back(64'(ma0));
                if (!mem_hold) begin mrv[0] <= 1'b1; rdat0 <= 32'(beat(64'(ma0), 4)); end
            end
            if (mreqv[1] && mem_req_ready) begin
                req_log.push_back(64'(ma1));
                if (!mem_hold) begin mrv[1] <= 1'b1; rdat1 <= 32'(beat(64'(ma1), 4)); end
            end
            if (mreqv[2] && mem_req_ready) begin
                req_log.push_back(ma2);
                if (!mem_hold) begin mrv[2] <= 1'b1; rdat2 <= beat(ma2, 8); end
            end
        end
    end

    // Reference: read the addressed bytes directly, little-endian, then extend.
    function automatic void model(input int xl, input bit mis, input logic [2:0] ff,
                                  input logic [63:0] a, output logic [63:0] d,
                                  output logic e, output int nreq);
        int size, nb, off;
        bit sgn, legal;
        logic [63:0] v;
        nb = xl / 8;
        legal = 1'b1; sgn = 1'b0; size = 0;
        case (ff)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd4: size = 1;
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd5: size = 2;
            3'd2: begin size = 4; sgn = 1'b1; end
            3'd6: begin size = 4; legal = (xl == 64); end
            3'd3: begin size = 8; sgn = 1'b1; legal = (xl == 64); end
            default: legal = 1'b0;
        endcase
        off = int'(a % 64'(nb));
        if (!legal || ((off + size > nb) && !mis)) begin
            d = '0; e = 1'b1; nreq = 0;
        end else begin
            v = '0;
            for (int i = 0; i < size; i++)
                v |= 64'(bmem[int'((a + 64'(i)) & 64'd511)]) << (8 * i);
            if (sgn && v[8*size-1]) v |= 64'hFFFF_FFFF_FFFF_FFFF << (8 * size);
            if (xl == 32) v &= 64'hFFFF_FFFF;
            d = v; e = 1'b0; nreq = (off + size > nb) ? 2 : 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_load(input int s, input logic [2:0] ff, input logic [63:0] a,
                           input logic [63:0] ed, input logic ee, input int enr,
                           input logic [63:0] ea0, input logic [63:0] ea1,
                           input int elat, input string nm);
        int base, cyc;
        base = req_log.size();
        sel = s;
        @(negedge clk);
        chk({nm, "_req_ready"}, 64'(c_rr), 64'd1);
        rv = 1'b1; f3 = ff; addr = a;
        @(negedge clk);
        rv = 1'b0;
        cyc = 1;
        while (!c_rv && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_resp_valid"}, 64'(c_rv), 64'd1);
        if (c_rv) begin
            chk({nm, "_latency"}, 64'(cyc), 64'(elat));
            chk({nm, "_data"}, c_rd, ed);
            chk({nm, "_err"}, 64'(c_err), 64'(ee));
        end
        chk({nm, "_nreq"}, 64'(req_log.size() - base), 64'(enr));
        if (enr > 0 && req_log.size() > base)     chk({nm, "_addr0"}, req_log[base], ea0);
        if (enr > 1 && req_log.size() > base + 1) chk({nm, "_addr1"}, req_log[base + 1], ea1);
    endtask

    typedef struct {
        int          s;
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] d;
        logic        e;
        int          nr;
        logic [63:0] a0;
        logic [63:0] a1;
        int          lat;
    } vec_t;

    vec_t vt [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, xl, nb, nr;
        logic e;
        logic [2:0] ff;
        logic [63:0] a, d, a0, a1;

        nchk = 0; nerr = 0;
        rst = 1'b1; rv = 1'b0; f3 = '0; addr = '0; sel = 0;
        mem_req_ready = 1'b1; resp_ready = 1'b1; mem_hold = 1'b0; inj_rv = 1'b0;
        for (int i = 0; i < 512; i++) bmem[i] = 8'($urandom);
        {bmem[259], bmem[258], bmem[257], bmem[256]} = 32'h8765_4321;
        {bmem[263], bmem[262], bmem[261], bmem[260]} = 32'hCAFE_BABE;
        {bmem[7], bmem[6], bmem[5], bmem[4], bmem[3], bmem[2], bmem[1], bmem[0]} = 64'h8000_0000_1122_3344;
        bmem[8] = 8'h01; bmem[510] = 8'h11; bmem[511] = 8'h22;

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d_req_ready", s), 64'(c_rr), 64'd1);
            chk($sformatf("rst%0d_mem_req_valid", s), 64'(c_mv), 64'd0);
            chk($sformatf("rst%0d_mem_addr", s), c_ma, 64'd0);
            chk($sformatf("rst%0d_resp_valid", s), 64'(c_rv), 64'd0);
            chk($sformatf("rst%0d_resp_data", s), c_rd, 64'd0);
            chk($sformatf("rst%0d_resp_err", s), 64'(c_err), 64'd0);
        end
        rst = 1'b0;

        vt[0]  = '{0, F3_LB,  64'h103, 64'hFFFF_FF87, 1'b0, 1, 64'h100, 64'h0, 3};
        vt[1]  = '{0, F3_LHU, 64'h102, 64'h0000_8765, 1'b0, 1, 64'h100, 64'h0, 3};
        vt[2]  = '{0, F3_LBU, 64'h101, 64'h0000_0043, 1'b0, 1, 64'h100, 64'h0, 3};
        vt[3]  = '{0, F3_LW,  64'h102, 64'hBABE_8765, 1'b0, 2, 64'h100, 64'h104, 5};
        vt[4]  = '{0, F3_LH,  64'h103, 64'hFFFF_BE87, 1'b0, 2, 64'h100, 64'h104, 5};
        vt[5]  = '{1, F3_LW,  64'h101, 64'h0, 1'b1, 0, 64'h0, 64'h0, 1};
        vt[6]  = '{0, F3_LD,  64'h100, 64'h0, 1'b1, 0, 64'h0, 64'h0, 1};
        vt[7]  = '{0, 3'b111, 64'h100, 64'h0, 1'b1, 0, 64'h0, 64'h0, 1};
        vt[8]  = '{2, F3_LD,  64'h0, 64'h8000_0000_1122_3344, 1'b0, 1, 64'h0, 64'h0, 3};
        vt[9]  = '{2, F3_LWU, 64'h4, 64'h0000_0000_8000_0000, 1'b0, 1, 64'h0, 64'h0, 3};
        vt[10] = '{2, F3_LW,  64'h4, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 64'h0, 64'h0, 3};
        vt[11] = '{0, F3_LW,  64'h100, 64'h8765_4321, 1'b0, 1, 64'h100, 64'h0, 3};
        vt[12] = '{0, F3_LW,  64'hFFFF_FFFE, 64'h3344_2211, 1'b0, 2, 64'hFFFF_FFFC, 64'h0, 5};
        vt[13] = '{1, F3_LH,  64'h102, 64'hFFFF_8765, 1'b0, 1, 64'h100, 64'h0, 3};
        vt[14] = '{2, F3_LH,  64'h7, 64'h180, 1'b0, 2, 64'h0, 64'h8, 5};
        vt[15] = '{0, F3_LWU, 64'h100, 64'h0, 1'b1, 0, 64'h0, 64'h0, 1};
        for (int i = 0; i < 16; i++)
            do_load(vt[i].s, vt[i].f3, vt[i].a, vt[i].d, vt[i].e, vt[i].nr,
                    vt[i].a0, vt[i].a1, vt[i].lat, $sformatf("vec%0d", i));

        // Memory stall: request must hold steady while not accepted.
        sel = 0; mem_req_ready = 1'b0;
        @(negedge clk);
        rv = 1'b1; f3 = F3_LW; addr = 64'h100;
        @(negedge clk);
        rv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mstall%0d_valid", k), 64'(c_mv), 64'd1);
            chk($sformatf("mstall%0d_addr", k), c_ma, 64'h100);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        cyc = 0;
        while (!c_rv && cyc < 40) begin @(negedge clk); cyc++; end
        chk("mstall_resp_valid", 64'(c_rv), 64'd1);
        chk("mstall_data", c_rd, 64'h8765_4321);

        // Consumer stall: response must hold and no new request accepted.
        @(negedge clk);
        resp_ready = 1'b0;
        rv = 1'b1; f3 = F3_LB; addr = 64'h103;
        @(negedge clk);
        rv = 1'b0;
        cyc = 0;
        while (!c_rv && cyc < 40) begin @(negedge clk); cyc++; end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rstall%0d_valid", k), 64'(c_rv), 64'd1);
            chk($sformatf("rstall%0d_data", k), c_rd, 64'hFFFF_FF87);
            chk($sformatf("rstall%0d_req_ready", k), 64'(c_rr), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("rstall_done_valid", 64'(c_rv), 64'd0);
        chk("rstall_done_req_ready", 64'(c_rr), 64'd1);

        // Reset while waiting for read data; a late beat must be ignored.
        mem_hold = 1'b1;
        rv = 1'b1; f3 = F3_LW; addr = 64'h100;
        @(negedge clk);
        rv = 1'b0;
        @(negedge clk);
        chk("midrst_wait_memv", 64'(c_mv), 64'd0);
        chk("midrst_wait_req_ready", 64'(c_rr), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_hold = 1'b0;
        chk("midrst_req_ready", 64'(c_rr), 64'd1);
        chk("midrst_memv", 64'(c_mv), 64'd0);
        chk("midrst_mem_addr", c_ma, 64'd0);
        chk("midrst_resp_valid", 64'(c_rv), 64'd0);
        inj_rv = 1'b1;
        @(negedge clk);
        inj_rv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("late%0d_resp_valid", k), 64'(c_rv), 64'd0);
            chk($sformatf("late%0d_req_ready", k), 64'(c_rr), 64'd1);
            @(negedge clk);
        end

        // Random loads against the byte-level reference.
        for (int i = 0; i < 512; i++) bmem[i] = 8'($urandom);
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 60; k++) begin
                xl = (s == 2) ? 64 : 32;
                nb = xl / 8;
                ff = 3'($urandom_range(0, 7));
                a  = 64'($urandom_range(0, 511));
                model(xl, s != 1, ff, a, d, e, nr);
                a0 = a & ~64'(nb - 1);
                a1 = a0 + 64'(nb);
                if (xl == 32) a1 &= 64'hFFFF_FFFF;
                do_load(s, ff, a, d, e, nr, a0, a1, e ? 1 : ((nr == 2) ? 5 : 3),
                        $sformatf("rnd%0d_%0d", s, k));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Sequential load path between the execute stage and the data-memory port. Accepts one load request (funct3, byte address) and issues one or two aligned XLEN-wide read beats to memory. A load that crosses an XLEN boundary is served by stitching the two beats together. The result is then aligned, sign- or zero-extended, and returned over a valid/ready handshake. Generalises the combinational load extender to XLEN 32/64, adds LD/LWU, misaligned split access and error reporting.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64.
MISALIGNED_EN, 1, 1: split boundary-crossing loads into two beats; 0: report them as errors.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  load request valid.
req_ready  out  1  unit can accept a request; 1 only in IDLE.
req_funct3  in  3  RISC-V load funct3.
req_addr  in  XLEN  byte address.
mem_req_valid  out  1  memory read request valid.
mem_req_ready  in  1  memory accepts request.
mem_addr  out  XLEN  aligned beat address; low log2(XLEN/8) bits are 0.
mem_rvalid  in  1  read data valid.
mem_rdata  in  XLEN  read beat.
resp_valid  out  1  result valid.
resp_ready  in  1  consumer accepts result.
resp_data  out  XLEN  extended load result.
resp_err  out  1  illegal funct3 or disallowed misalignment.

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_req_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0.
- Size by funct3:
  - 000 LB / 100 LBU: 1 byte.
  - 001 LH / 101 LHU: 2 bytes.
  - 010 LW: 4 bytes.
  - 110 LWU: 4 bytes, XLEN=64 only.
  - 011 LD: 8 bytes, XLEN=64 only.
  - All other funct3 values are illegal.
- Definitions: off = addr mod (XLEN/8); split = (off + size) > XLEN/8.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on req_valid && req_ready, latch funct3 and addr.
  - Illegal funct3, or split with MISALIGNED_EN=0: go to RESP with resp_err=1, resp_data=0. No memory access.
  - Otherwise: go to REQ0.
- REQ0: mem_req_valid=1, mem_addr=aligned(addr). On mem_req_ready, go to WAIT0.
- WAIT0: on mem_rvalid, capture beat0. If split, go to REQ1; else go to RESP.
- REQ1: mem_addr = aligned(addr) + XLEN/8, with natural wrap at the top of the address space. On mem_req_ready, go to WAIT1.
- WAIT1: on mem_rvalid, capture beat1 and go to RESP.
- Result formation:
  - Form {beat1, beat0} (beat1=0 if not split).
  - Shift right by off*8 and take the low size*8 bits.
  - Sign-extend for LB/LH/LW(XLEN=64)/LD; zero-extend for LBU/LHU/LWU.
  - With XLEN=32, LW returns the word unchanged.
  - resp_data is registered on entry to RESP.
- RESP: resp_valid=1; resp_data and resp_err stay stable until resp_ready, then go to IDLE.
- Minimum latency (accept at cycle T, mem_req_ready=1, mem_rvalid the cycle after the request):
  - Non-split: mem_req_valid at T+1, resp_valid at T+3.
  - Split: resp_valid at T+5.
  - Error: resp_valid at T+1.
- Outputs stay stable while the memory side stalls (mem_req_ready=0) or the consumer stalls (resp_ready=0).
- mem_rvalid is ignored outside WAIT0/WAIT1. At most one memory request is outstanding.
- No back-to-back overlap: req_ready=0 from the accept cycle until the cycle after the RESP handshake.
- Reset mid-operation: the next state is IDLE and outputs take reset values. Memory is reset on the same rst, so no stale beat is expected.

Decomposition:
- Shared package load_pkg holds:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU).
  - The FSM state encoding.
  - A size-from-funct3 function.
- One combinational sub-module, load_align_ext: takes beat0, beat1, off, funct3 and produces the extended result. It is parametrised by XLEN and reused by the future store/AMO path.

Test Plan:
- XLEN=32, mem[0x100]=0x87654321, mem[0x104]=0xCAFEBABE. LB @0x103 -> one request at 0x100, resp_data=0xFFFFFF87, err=0.
- LHU @0x102 -> resp_data=0x00008765. LBU @0x101 -> 0x00000043.
- MISALIGNED_EN=1: LW @0x102 -> requests 0x100 then 0x104, resp_data=0xBABE8765. LH @0x103 -> resp_data=0xFFFFBE87.
- MISALIGNED_EN=0: LW @0x101 -> resp_err=1, resp_data=0, no mem_req_valid. XLEN=32 with funct3=011 -> resp_err=1.
- XLEN=64, mem[0x0]=0x8000000011223344: LD @0x0 -> 0x8000000011223344. LWU @0x4 -> 0x0000000080000000. LW @0x4 -> 0xFFFFFFFF80000000.
- Stalls and reset:
  - Hold mem_req_ready=0 for 3 cycles -> mem_addr and mem_req_valid stable.
  - Hold resp_ready=0 for 2 cycles -> resp_data stable.
  - Assert rst in WAIT0 -> IDLE next cycle with req_ready=1; a late mem_rvalid produces no response.
